sprite_line_scheduler: RTL and testbench
========================================

// Module: sprite_line_scheduler
// PURPOSE
//  Shares one synchronous 32x32x4bpp sprite ROM (4 direction banks) among N_SPR game objects (tanks, bullets).
//  During each horizontal blank it scans all objects and builds the list of sprites on the next scanline.
//  During active video it picks the winning sprite per pixel and drives the ROM address.
//  It returns a palette index plus a hit flag to the colour mapper, pipeline-aligned to DrawX/DrawY.
// PARAMETERS
//  N_SPR        8    objects scanned per line (scan must fit in hblank: N_SPR <= 150)
//  MAX_PER_LINE 4    sprite slots per scanline; excess sprites are dropped for that line
//  SPR_W        32   sprite width/height in pixels (power of 2)
//  H_ACTIVE     640  visible pixels per line;  H_TOTAL 800
//  V_TOTAL      525  lines per frame
// PORTS
//  vga_clk      in   1              pixel clock
//  reset        in   1              async, active-high
//  DrawX        in   10             current pixel column
//  DrawY        in   10             current pixel row
//  blank        in   1              1 = visible region
//  spr_en       in   N_SPR          object enable
//  spr_x        in   N_SPR*10       object left edge (packed, obj 0 in LSBs)
//  spr_y        in   N_SPR*10       object top edge
//  spr_dir      in   N_SPR*2        0 up, 1 right, 2 down, 3 left (ROM bank)
//  rom_addr     out  12             {dir,row[4:0],col[4:0]} to sprite ROM (1-cycle read latency)
//  rom_q        in   4              ROM data
//  pix_hit      out  1              opaque sprite pixel at pix_x/pix_y
//  pix_index    out  4              palette index (0 when !pix_hit)
//  pix_id       out  $clog2(N_SPR)  winning object number
//  pix_x,pix_y  out  10             coordinates of pix_* (DrawX/DrawY delayed 2)
//  line_ovf     out  1              sticky per line: >MAX_PER_LINE sprites found in last scan
// BEHAVIOUR
//  Reset: all outputs 0, FSM IDLE, both slot lists empty, pipeline valid bits cleared.
//  FSM: IDLE -> SCAN when DrawX==H_ACTIVE; SCAN visits obj 0..N_SPR-1, one per cycle; -> DONE after
//    obj N_SPR-1; DONE -> IDLE when DrawX==H_TOTAL-1, copying scan list to active list that cycle.
//  Scan target line ny = (DrawY==V_TOTAL-1) ? 0 : DrawY+1. Obj i qualifies if spr_en[i] and
//    spr_y[i] <= ny < spr_y[i]+SPR_W (11-bit compare, no wrap; sprites clipped at screen edges).
//  Qualifying objects fill slots in index order; slot stores id, x, dir, row=ny-spr_y[i] (5b).
//  A qualifying object found with all slots full sets line_ovf (cleared at next SCAN entry).
//  Inputs sampled once per object during SCAN; changes later in the line take effect next line.
//  Pixel pipe, stage0 (cycle of DrawX): slot s hits if valid and x <= DrawX < x+SPR_W;
//    lowest slot wins (= lowest object id). rom_addr registered = {dir,row,DrawX-x}.
//    No hit or !blank: rom_addr holds last value, stage valid = 0.
//  stage1: ROM returns rom_q. stage2 (registered outputs):
//    pix_hit = valid & (rom_q!=0); pix_index = pix_hit ? rom_q : 0.
//    Total latency DrawX -> pix_* = 2 cycles.
//  Index 0 is transparent. No fallback to a lower-priority overlapping sprite (single ROM port).
//  reset mid-line: pipe flushes immediately. Lists are empty until the next full hblank scan,
//    so at most one line shows no sprites.
//  Line V_TOTAL-1 scan builds line 0's list (frame wrap).
// STRUCTURE
//  Package sprite_pkg: H_ACTIVE/H_TOTAL/V_TOTAL/SPR_W constants, dir_e enum,
//    slot_t struct {valid,id,x,dir,row}.
//  Sub-module sprite_slot_match: combinational per-slot hit + priority encode, instantiated once.
//  Scan FSM and list double buffer live in the top level.
// TESTING
//  1 obj 0 at (100,50) dir 2. At DrawY=49 -> scan finds it. On line 50, DrawX=100 gives rom_addr=0x800;
//    pix_hit with pix_x=100 two cycles later; DrawX=132 gives no hit.
//  Objs 0 and 1 both at (200,200), ROM nonzero. pix_id=0 everywhere on overlap; disabling obj 0 -> pix_id=1.
//  6 objs on line 300, MAX_PER_LINE=4. Only ids 0..3 render; line_ovf=1 during line 300;
//    line_ovf clears on the line-300 hblank scan.
//  Obj at y=510 (rows 510..541): draws on rows 510..524 only. Obj at y=0 appears on line 0 via the scan on line 524.
//  ROM returns 0 at the sprite center -> pix_hit=0, pix_index=0 there.
//    blank=0 over a sprite -> no hits.
//  Assert reset at DrawX=300 of a sprite line. All outputs 0 within the same cycle.
//    Release: no hits for the rest of that line; normal output on the next line.

Source files
------------

// File: rtl/sprite_line_scheduler_pkg.sv
// Shared constants, direction enum, slot record and span helper for the
// sprite line scheduler.
package sprite_pkg;

  localparam int H_ACTIVE = 640;
  localparam int H_TOTAL  = 800;
  localparam int V_TOTAL  = 525;
  localparam int SPR_W    = 32;
  localparam int ID_W     = 8;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_RIGHT = 2'd1,
    DIR_DOWN  = 2'd2,
    DIR_LEFT  = 2'd3
  } dir_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } scan_state_e;

  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
    logic [9:0]      x;
    dir_e            dir;
    logic [4:0]      row;
  } slot_t;

  // True when v lies in [lo, lo+SPR_W); 11-bit so a sprite near the edge never wraps.
  function automatic logic in_span(input logic [9:0] lo, input logic [9:0] v);
    logic [10:0] lo_e;
    logic [10:0] v_e;
    lo_e = {1'b0, lo};
    v_e  = {1'b0, v};
    return (v_e >= lo_e) && (v_e < lo_e + 11'(SPR_W));
  endfunction

endpackage

// File: rtl/sprite_line_scheduler_if.sv
// Video timing, object table, sprite ROM port and pixel result bundle.
interface sprite_line_scheduler_if #(parameter int N_SPR = 8);

  logic [9:0]               DrawX;
  logic [9:0]               DrawY;
  logic                     blank;
  logic [N_SPR-1:0]         spr_en;
  logic [N_SPR*10-1:0]      spr_x;
  logic [N_SPR*10-1:0]      spr_y;
  logic [N_SPR*2-1:0]       spr_dir;
  logic [11:0]              rom_addr;
  logic [3:0]               rom_q;
  logic                     pix_hit;
  logic [3:0]               pix_index;
  logic [$clog2(N_SPR)-1:0] pix_id;
  logic [9:0]               pix_x;
  logic [9:0]               pix_y;
  logic                     line_ovf;

  modport master (
    output DrawX, DrawY, blank, spr_en, spr_x, spr_y, spr_dir, rom_q,
    input  rom_addr, pix_hit, pix_index, pix_id, pix_x, pix_y, line_ovf
  );

  modport slave (
    input  DrawX, DrawY, blank, spr_en, spr_x, spr_y, spr_dir, rom_q,
    output rom_addr, pix_hit, pix_index, pix_id, pix_x, pix_y, line_ovf
  );

endinterface

// File: rtl/sprite_line_scheduler_slot_match.sv
// Per-slot horizontal hit test with lowest-slot-wins priority.
module sprite_slot_match
  import sprite_pkg::*;
#(
  parameter int N_SLOT = 4
) (
  input  slot_t           slots [N_SLOT],
  input  logic [9:0]      draw_x,
  output logic            hit,
  output logic [ID_W-1:0] win_id,
  output dir_e            win_dir,
  output logic [4:0]      win_row,
  output logic [4:0]      win_col
);

  // Walk from the highest slot down so the lowest matching slot is assigned last.
  always_comb begin
    hit     = 1'b0;
    win_id  = '0;
    win_dir = DIR_UP;
    win_row = '0;
    win_col = '0;
    for (int s = N_SLOT - 1; s >= 0; s--) begin
      if (slots[s].valid && in_span(slots[s].x, draw_x)) begin
        hit     = 1'b1;
        win_id  = slots[s].id;
        win_dir = slots[s].dir;
        win_row = slots[s].row;
        win_col = 5'(draw_x - slots[s].x);
      end
    end
  end

endmodule

// File: rtl/sprite_line_scheduler.sv
// Builds the next scanline's sprite list during hblank and picks one sprite
// per pixel in active video, returning palette index two cycles after DrawX.
module sprite_line_scheduler
  import sprite_pkg::*;
#(
  parameter int N_SPR        = 8,
  parameter int MAX_PER_LINE = 4
) (
  input logic               vga_clk,
  input logic               reset,
  sprite_line_scheduler_if.slave bus
);

  localparam int IDX_W  = $clog2(N_SPR);
  localparam int SLOT_W = $clog2(MAX_PER_LINE);
  localparam int CNT_W  = $clog2(MAX_PER_LINE + 1);

  scan_state_e      state, state_nxt;
  logic             scan_start, list_swap;
  logic [IDX_W-1:0] scan_idx;
  logic [CNT_W-1:0] scan_cnt;
  slot_t            scan_list [MAX_PER_LINE];
  slot_t            act_list  [MAX_PER_LINE];
  slot_t            new_slot;
  logic             obj_hit;
  logic             ovf_q;
  logic [9:0]       next_line;

  logic             obj_en  [N_SPR];
  logic [9:0]       obj_x   [N_SPR];
  logic [9:0]       obj_y   [N_SPR];
  logic [1:0]       obj_dir [N_SPR];

  for (genvar i = 0; i < N_SPR; i++) begin : g_unpack
    assign obj_en[i]  = bus.spr_en[i];
    assign obj_x[i]   = bus.spr_x[i*10 +: 10];
    assign obj_y[i]   = bus.spr_y[i*10 +: 10];
    assign obj_dir[i] = bus.spr_dir[i*2 +: 2];
  end

  assign next_line = (bus.DrawY == 10'(V_TOTAL - 1)) ? 10'd0 : bus.DrawY + 10'd1;

  // Scan FSM: start at end of active video, one object per cycle, swap lists at line end.
  always_comb begin
    state_nxt  = state;
    scan_start = 1'b0;
    list_swap  = 1'b0;
    case (state)
      ST_IDLE: if (bus.DrawX == 10'(H_ACTIVE)) begin
        state_nxt  = ST_SCAN;
        scan_start = 1'b1;
      end
      ST_SCAN: if (scan_idx == IDX_W'(N_SPR - 1)) state_nxt = ST_DONE;
      ST_DONE: if (bus.DrawX == 10'(H_TOTAL - 1)) begin
        state_nxt = ST_IDLE;
        list_swap = 1'b1;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Qualify the object under the scan pointer against the upcoming line.
  always_comb begin
    new_slot = '0;
    obj_hit  = 1'b0;
    if (state == ST_SCAN && obj_en[scan_idx] && in_span(obj_y[scan_idx], next_line)) begin
      obj_hit        = 1'b1;
      new_slot.valid = 1'b1;
      new_slot.id    = ID_W'(scan_idx);
      new_slot.x     = obj_x[scan_idx];
      new_slot.dir   = dir_e'(obj_dir[scan_idx]);
      new_slot.row   = 5'(next_line - obj_y[scan_idx]);
    end
  end

  // State register, scan list fill with overflow flag, and list double buffer.
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      scan_idx <= '0;
      scan_cnt <= '0;
      ovf_q    <= 1'b0;
      for (int s = 0; s < MAX_PER_LINE; s++) begin
        scan_list[s] <= '0;
        act_list[s]  <= '0;
      end
    end else begin
      state <= state_nxt;
      if (scan_start) begin
        scan_idx <= '0;
        scan_cnt <= '0;
        ovf_q    <= 1'b0;
        for (int s = 0; s < MAX_PER_LINE; s++) scan_list[s].valid <= 1'b0;
      end else if (state == ST_SCAN) begin
        scan_idx <= scan_idx + 1'b1;
        if (obj_hit) begin
          if (scan_cnt < CNT_W'(MAX_PER_LINE)) begin
            scan_list[scan_cnt[SLOT_W-1:0]] <= new_slot;
            scan_cnt <= scan_cnt + 1'b1;
          end else begin
            ovf_q <= 1'b1;
          end
        end
      end
      if (list_swap) begin
        for (int s = 0; s < MAX_PER_LINE; s++) act_list[s] <= scan_list[s];
      end
    end
  end

  logic            m_hit;
  logic [ID_W-1:0] m_id;
  dir_e            m_dir;
  logic [4:0]      m_row;
  logic [4:0]      m_col;

  sprite_slot_match #(.N_SLOT(MAX_PER_LINE)) u_match (
    .slots   (act_list),
    .draw_x  (bus.DrawX),
    .hit     (m_hit),
    .win_id  (m_id),
    .win_dir (m_dir),
    .win_row (m_row),
    .win_col (m_col)
  );

  logic unused_id_bits;
  assign unused_id_bits = &{1'b0, m_id[ID_W-1:IDX_W]};

  logic [11:0]      rom_addr_q;
  logic             s1_valid;
  logic [IDX_W-1:0] s1_id;
  logic [9:0]       s1_x, s1_y;
  logic             pix_hit_q;
  logic [3:0]       pix_index_q;
  logic [IDX_W-1:0] pix_id_q;
  logic [9:0]       pix_x_q, pix_y_q;

  // Stage 0: register ROM address for a visible winning pixel; address holds otherwise.
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      rom_addr_q <= '0;
      s1_valid   <= 1'b0;
      s1_id      <= '0;
      s1_x       <= '0;
      s1_y       <= '0;
    end else begin
      s1_x <= bus.DrawX;
      s1_y <= bus.DrawY;
      if (bus.blank && m_hit) begin
        rom_addr_q <= {m_dir, m_row, m_col};
        s1_valid   <= 1'b1;
        s1_id      <= m_id[IDX_W-1:0];
      end else begin
        s1_valid   <= 1'b0;
      end
    end
  end

  // Stage 2: combine ROM data with the valid bit; index 0 is transparent.
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      pix_hit_q   <= 1'b0;
      pix_index_q <= '0;
      pix_id_q    <= '0;
      pix_x_q     <= '0;
      pix_y_q     <= '0;
    end else begin
      pix_hit_q   <= s1_valid && (bus.rom_q != 4'd0);
      pix_index_q <= (s1_valid && (bus.rom_q != 4'd0)) ? bus.rom_q : 4'd0;
      pix_id_q    <= (s1_valid && (bus.rom_q != 4'd0)) ? s1_id : '0;
      pix_x_q     <= s1_x;
      pix_y_q     <= s1_y;
    end
  end

  assign bus.rom_addr  = rom_addr_q;
  assign bus.pix_hit   = pix_hit_q;
  assign bus.pix_index = pix_index_q;
  assign bus.pix_id    = pix_id_q;
  assign bus.pix_x     = pix_x_q;
  assign bus.pix_y     = pix_y_q;
  assign bus.line_ovf  = ovf_q;

endmodule

// File: tb/tb_sprite_line_scheduler.sv
// Directed bench for sprite_line_scheduler: runs selected scanlines, records
// per-column results, then compares against hand-computed values.
module tb_sprite_line_scheduler;

  logic vga_clk;
  logic reset;
  logic blank_on;

  int n_checks;
  int n_pass;

  logic        hit_at  [800];
  logic [3:0]  idx_at  [800];
  logic [2:0]  id_at   [800];
  logic [9:0]  px_at   [800];
  logic [9:0]  py_at   [800];
  logic [11:0] addr_at [800];
  logic        ovf_at  [800];

  sprite_line_scheduler_if #(.N_SPR(8)) bus ();

  sprite_line_scheduler #(.N_SPR(8), .MAX_PER_LINE(4)) dut (
    .vga_clk (vga_clk),
    .reset   (reset),
    .bus     (bus)
  );

  // Sprite ROM model: nonzero everywhere except the centre pixel (row 16, col 16).
  assign bus.rom_q = (bus.rom_addr[9:0] == 10'h210) ? 4'h0 : {1'b1, bus.rom_addr[2:0]};

  // Pixel clock.
  initial vga_clk = 1'b0;
  always #5 vga_clk = ~vga_clk;

  task automatic check_output(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic set_obj(input int i, input bit en, input int x, input int y, input int dir);
    bus.spr_en[i]          = en;
    bus.spr_x[i*10 +: 10]  = 10'(x);
    bus.spr_y[i*10 +: 10]  = 10'(y);
    bus.spr_dir[i*2 +: 2]  = 2'(dir);
  endtask

  task automatic clear_objs();
    bus.spr_en  = '0;
    bus.spr_x   = '0;
    bus.spr_y   = '0;
    bus.spr_dir = '0;
  endtask

  // Run one full scanline; pixel results are filed under the DrawX they belong to.
  task automatic apply_stimulus(input int y, input int rst_at);
    for (int x = 0; x < 800; x++) begin
      hit_at[x] = 1'b0; idx_at[x] = '0; id_at[x] = '0;
      px_at[x] = '0; py_at[x] = '0; addr_at[x] = '0; ovf_at[x] = 1'b0;
    end
    for (int x = 0; x < 800; x++) begin
      bus.DrawX = 10'(x);
      bus.DrawY = 10'(y);
      bus.blank = blank_on && (x < 640);
      if (x == rst_at) begin
        reset = 1'b1;
        #1;
        check_output("reset_mid_line_outputs", {23'd0, bus.rom_addr, bus.pix_hit, bus.pix_index,
                     bus.pix_id, bus.pix_x, bus.pix_y, bus.line_ovf}, 64'd0);
      end
      if (x == rst_at + 3) reset = 1'b0;
      @(posedge vga_clk);
      #1;
      addr_at[x] = bus.rom_addr;
      ovf_at[x]  = bus.line_ovf;
      if (x > 0) begin
        hit_at[x-1] = bus.pix_hit;
        idx_at[x-1] = bus.pix_index;
        id_at[x-1]  = bus.pix_id;
        px_at[x-1]  = bus.pix_x;
        py_at[x-1]  = bus.pix_y;
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    blank_on = 1'b1;
    reset    = 1'b1;
    bus.DrawX = '0;
    bus.DrawY = '0;
    bus.blank = 1'b0;
    clear_objs();
    repeat (3) @(posedge vga_clk);
    #1;
    check_output("reset_outputs", {23'd0, bus.rom_addr, bus.pix_hit, bus.pix_index,
                 bus.pix_id, bus.pix_x, bus.pix_y, bus.line_ovf}, 64'd0);
    reset = 1'b0;

    // Single sprite at (100,50), direction down.
    $display("[TB] single sprite");
    set_obj(0, 1, 100, 50, 2);
    apply_stimulus(49, -1);
    apply_stimulus(50, -1);
    check_output("single_addr_x100", addr_at[100], 64'h800);
    check_output("single_hit_x100", {hit_at[100], idx_at[100], id_at[100]}, {1'b1, 4'h8, 3'd0});
    check_output("single_pix_xy", {px_at[100], py_at[100]}, {10'd100, 10'd50});
    check_output("single_addr_x105", addr_at[105], 64'h805);
    check_output("single_hit_x131", {hit_at[131], idx_at[131]}, {1'b1, 4'hF});
    check_output("single_nohit_x132", {hit_at[132], idx_at[132]}, 5'd0);
    check_output("single_nohit_x99", hit_at[99], 1'b0);

    // Two overlapping sprites: lowest id wins, then obj 0 disabled.
    $display("[TB] overlap priority");
    clear_objs();
    set_obj(0, 1, 200, 200, 0);
    set_obj(1, 1, 200, 200, 1);
    apply_stimulus(199, -1);
    apply_stimulus(200, -1);
    check_output("overlap_id_x200", {hit_at[200], id_at[200]}, {1'b1, 3'd0});
    check_output("overlap_id_x231", {hit_at[231], id_at[231]}, {1'b1, 3'd0});
    check_output("overlap_addr_x200", addr_at[200], 64'h000);
    check_output("overlap_addr_x215", addr_at[215], 64'h00F);
    set_obj(0, 0, 200, 200, 0);
    apply_stimulus(201, -1);
    apply_stimulus(202, -1);
    check_output("overlap_obj1_id", {hit_at[210], id_at[210]}, {1'b1, 3'd1});
    check_output("overlap_obj1_addr", addr_at[210], 64'h44A);

    // Six sprites on line 300; only four slots.
    $display("[TB] slot overflow");
    clear_objs();
    for (int i = 0; i < 4; i++) set_obj(i, 1, i * 40, 300, 0);
    set_obj(4, 1, 160, 269, 0);
    set_obj(5, 1, 200, 269, 0);
    apply_stimulus(299, -1);
    apply_stimulus(300, -1);
    check_output("ovf_set_line300", ovf_at[10], 1'b1);
    check_output("ovf_id0", {hit_at[5], id_at[5]}, {1'b1, 3'd0});
    check_output("ovf_id3", {hit_at[125], id_at[125]}, {1'b1, 3'd3});
    check_output("ovf_drop_id4", hit_at[165], 1'b0);
    check_output("ovf_drop_id5", hit_at[205], 1'b0);
    check_output("ovf_cleared_after_scan", ovf_at[799], 1'b0);

    // Transparent centre pixel, then blank low over the sprite.
    $display("[TB] transparency and blank");
    clear_objs();
    set_obj(0, 1, 400, 100, 1);
    apply_stimulus(115, -1);
    apply_stimulus(116, -1);
    check_output("centre_addr", addr_at[416], 64'h610);
    check_output("centre_transparent", {hit_at[416], idx_at[416]}, 5'd0);
    check_output("centre_next_opaque", {hit_at[417], idx_at[417]}, {1'b1, 4'h9});
    blank_on = 1'b0;
    apply_stimulus(117, -1);
    check_output("blank_nohit", hit_at[410], 1'b0);
    check_output("blank_addr_holds", addr_at[410], 64'h61F);
    blank_on = 1'b1;

    // Reset asserted at DrawX=300 on a sprite line.
    $display("[TB] mid-line reset");
    clear_objs();
    set_obj(0, 1, 280, 150, 0);
    apply_stimulus(149, -1);
    apply_stimulus(150, 300);
    check_output("rst_line_before", hit_at[290], 1'b1);
    check_output("rst_line_after", hit_at[308], 1'b0);
    apply_stimulus(151, -1);
    check_output("rst_next_line_hit", hit_at[290], 1'b1);
    check_output("rst_next_line_addr", addr_at[290], 64'h02A);

    // Bottom clipping and frame wrap.
    $display("[TB] frame edges");
    clear_objs();
    set_obj(0, 1, 100, 510, 0);
    set_obj(1, 1, 300, 0, 3);
    apply_stimulus(523, -1);
    apply_stimulus(524, -1);
    check_output("bottom_hit_row524", {hit_at[100], id_at[100]}, {1'b1, 3'd0});
    check_output("bottom_addr_row524", addr_at[100], 64'h1C0);
    check_output("top_obj_absent_524", hit_at[300], 1'b0);
    apply_stimulus(0, -1);
    check_output("wrap_obj1_line0", {hit_at[300], id_at[300]}, {1'b1, 3'd1});
    check_output("wrap_addr_line0", addr_at[300], 64'hC00);
    check_output("no_wrap_obj0_line0", hit_at[100], 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
